// File: rtl/fmc_adc_time_trig_seq.sv
// White Rabbit time-compare trigger sequencer: up to 16 armed slots fire trig_o when TAI time reaches their target.
// Optional periodic re-arm with repeat count is compiled in by FMC_ADC_TIME_TRIG_PERIODIC_EN.
`timescale 1ns/1ps

module fmc_adc_time_trig_seq #(
  parameter int g_NB_SLOTS       = 4,
  parameter int g_CYCLES_PER_SEC = 125000000
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst_n_i,
  input  logic                  wr_tm_time_valid_i,
  input  logic [39:0]           wr_tm_tai_i,
  input  logic [27:0]           wr_tm_cycles_i,
  input  logic                  cfg_wr_i,
  input  logic [3:0]            cfg_slot_i,
  input  logic [39:0]           cfg_sec_i,
  input  logic [27:0]           cfg_cyc_i,
  input  logic [27:0]           cfg_period_i,
  input  logic [15:0]           cfg_count_i,
  input  logic [g_NB_SLOTS-1:0] cfg_disarm_i,
  output logic [g_NB_SLOTS-1:0] armed_o,
  output logic                  trig_o,
  output logic [3:0]            trig_slot_o,
  output logic [39:0]           trig_sec_o,
  output logic [27:0]           trig_cyc_o,
  output logic                  trig_late_o
);

  logic [g_NB_SLOTS-1:0] armed_q;
  logic [g_NB_SLOTS-1:0] pend_q;
  logic [g_NB_SLOTS-1:0] late_q;
  logic [g_NB_SLOTS-1:0] cmp;
  logic [g_NB_SLOTS-1:0] gt;
  logic [g_NB_SLOTS-1:0] wr_hit;
  logic [g_NB_SLOTS-1:0] kill;
  logic [g_NB_SLOTS-1:0] sel;
  logic [39:0]           sec_q [g_NB_SLOTS];
  logic [27:0]           cyc_q [g_NB_SLOTS];
  logic [67:0]           now;
  logic                  sel_vld;
  logic [3:0]            sel_idx;
  logic [39:0]           sel_sec;
  logic [27:0]           sel_cyc;
  logic                  sel_late;

  assign now     = {wr_tm_tai_i, wr_tm_cycles_i};
  assign armed_o = armed_q;

  always_comb begin
    wr_hit = '0;
    kill   = '0;
    cmp    = '0;
    gt     = '0;
    for (int i = 0; i < g_NB_SLOTS; i++) begin
      wr_hit[i] = cfg_wr_i && (cfg_slot_i == 4'(i));
      kill[i]   = wr_hit[i] || cfg_disarm_i[i];
      cmp[i]    = armed_q[i] && wr_tm_time_valid_i && (now >= {sec_q[i], cyc_q[i]});
      gt[i]     = now > {sec_q[i], cyc_q[i]};
    end
  end

  // Scanning downward lets the lowest pending, non-killed slot win the output stage.
  always_comb begin
    sel      = '0;
    sel_vld  = 1'b0;
    sel_idx  = '0;
    sel_sec  = '0;
    sel_cyc  = '0;
    sel_late = 1'b0;
    for (int i = g_NB_SLOTS - 1; i >= 0; i--) begin
      if (pend_q[i] && !kill[i]) begin
        sel      = '0;
        sel[i]   = 1'b1;
        sel_vld  = 1'b1;
        sel_idx  = 4'(i);
        sel_sec  = sec_q[i];
        sel_cyc  = cyc_q[i];
        sel_late = late_q[i];
      end
    end
  end

`ifdef FMC_ADC_TIME_TRIG_PERIODIC_EN
  localparam logic [27:0] c_CPS        = 28'(g_CYCLES_PER_SEC);
  localparam logic [27:0] c_PERIOD_MAX = 28'(g_CYCLES_PER_SEC - 1);

  logic [27:0] per_q   [g_NB_SLOTS];
  logic [15:0] cnt_q   [g_NB_SLOTS];
  logic [39:0] nxt_sec [g_NB_SLOTS];
  logic [27:0] nxt_cyc [g_NB_SLOTS];
  logic [27:0] per_load;
  logic [28:0] sum;

  // Next target after a periodic fire, wrapping cycles into the following second.
  always_comb begin
    per_load = (cfg_period_i >= c_CPS) ? c_PERIOD_MAX : cfg_period_i;
    sum      = '0;
    for (int i = 0; i < g_NB_SLOTS; i++) begin
      sum        = {1'b0, cyc_q[i]} + {1'b0, per_q[i]};
      nxt_sec[i] = sec_q[i];
      nxt_cyc[i] = sum[27:0];
      if (sum >= {1'b0, c_CPS}) begin
        nxt_cyc[i] = 28'(sum - {1'b0, c_CPS});
        nxt_sec[i] = sec_q[i] + 40'd1;
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_period_i, cfg_count_i};
`endif

  // Pending is sticky from the first matching compare so late reflects that sample.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      armed_q <= '0;
      pend_q  <= '0;
      late_q  <= '0;
      for (int i = 0; i < g_NB_SLOTS; i++) begin
        sec_q[i] <= '0;
        cyc_q[i] <= '0;
`ifdef FMC_ADC_TIME_TRIG_PERIODIC_EN
        per_q[i] <= '0;
        cnt_q[i] <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < g_NB_SLOTS; i++) begin
        if (wr_hit[i]) begin
          armed_q[i] <= 1'b1;
          pend_q[i]  <= 1'b0;
          sec_q[i]   <= cfg_sec_i;
          cyc_q[i]   <= cfg_cyc_i;
`ifdef FMC_ADC_TIME_TRIG_PERIODIC_EN
          per_q[i]   <= per_load;
          cnt_q[i]   <= cfg_count_i;
`endif
        end else if (cfg_disarm_i[i]) begin
          armed_q[i] <= 1'b0;
          pend_q[i]  <= 1'b0;
        end else if (sel[i]) begin
          pend_q[i] <= 1'b0;
`ifdef FMC_ADC_TIME_TRIG_PERIODIC_EN
          if (per_q[i] != '0 && cnt_q[i] != 16'd1) begin
            sec_q[i] <= nxt_sec[i];
            cyc_q[i] <= nxt_cyc[i];
            if (cnt_q[i] != '0)
              cnt_q[i] <= cnt_q[i] - 16'd1;
          end else begin
            armed_q[i] <= 1'b0;
          end
`else
          armed_q[i] <= 1'b0;
`endif
        end else if (cmp[i] && !pend_q[i]) begin
          pend_q[i] <= 1'b1;
          late_q[i] <= gt[i];
        end
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      trig_o      <= 1'b0;
      trig_slot_o <= '0;
      trig_sec_o  <= '0;
      trig_cyc_o  <= '0;
      trig_late_o <= 1'b0;
    end else begin
      trig_o <= sel_vld;
      if (sel_vld) begin
        trig_slot_o <= sel_idx;
        trig_sec_o  <= sel_sec;
        trig_cyc_o  <= sel_cyc;
        trig_late_o <= sel_late;
      end
    end
  end

endmodule

// File: tb/tb_fmc_adc_time_trig_seq.sv
// Scoreboard bench for fmc_adc_time_trig_seq: directed arming scenarios push expected fires, a monitor checks each trig_o.
`timescale 1ns/1ps

module tb_fmc_adc_time_trig_seq;

  localparam int          CPS = 125000000;
  localparam logic [39:0] S   = 40'h3200005a34;

  typedef struct {
    logic [3:0]  slot;
    logic [39:0] sec;
    logic [27:0] cyc;
    logic        late;
    logic [27:0] tm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tm_valid;
  logic [39:0] tm_sec;
  logic [27:0] tm_cyc;
  logic        tm_run;
  logic        cfg_wr;
  logic [3:0]  cfg_slot;
  logic [39:0] cfg_sec;
  logic [27:0] cfg_cyc;
  logic [27:0] cfg_period;
  logic [15:0] cfg_count;
  logic [3:0]  cfg_disarm;
  logic [3:0]  armed;
  logic        trig;
  logic [3:0]  trig_slot;
  logic [39:0] trig_sec;
  logic [27:0] trig_cyc;
  logic        trig_late;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic [27:0] x;
  logic [27:0] z;

  fmc_adc_time_trig_seq dut (
    .sys_clk_i          (clk),
    .sys_rst_n_i        (rst_n),
    .wr_tm_time_valid_i (tm_valid),
    .wr_tm_tai_i        (tm_sec),
    .wr_tm_cycles_i     (tm_cyc),
    .cfg_wr_i           (cfg_wr),
    .cfg_slot_i         (cfg_slot),
    .cfg_sec_i          (cfg_sec),
    .cfg_cyc_i          (cfg_cyc),
    .cfg_period_i       (cfg_period),
    .cfg_count_i        (cfg_count),
    .cfg_disarm_i       (cfg_disarm),
    .armed_o            (armed),
    .trig_o             (trig),
    .trig_slot_o        (trig_slot),
    .trig_sec_o         (trig_sec),
    .trig_cyc_o         (trig_cyc),
    .trig_late_o        (trig_late)
  );

  always #5 clk = ~clk;

  // Free-running White Rabbit timebase, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (tm_run) begin
      if (tm_cyc == 28'(CPS - 1)) begin
        tm_cyc = '0;
        tm_sec = tm_sec + 40'd1;
      end else begin
        tm_cyc = tm_cyc + 28'd1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [67:0] act, input logic [67:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [3:0] slot, input logic [39:0] sec,
                               input logic [27:0] cyc, input logic [27:0] per,
                               input logic [15:0] cnt, input logic [3:0] dis);
    cfg_wr     = wr;
    cfg_slot   = slot;
    cfg_sec    = sec;
    cfg_cyc    = cyc;
    cfg_period = per;
    cfg_count  = cnt;
    cfg_disarm = dis;
    @(negedge clk);
    cfg_wr     = 1'b0;
    cfg_disarm = '0;
  endtask

  task automatic pushExp(input logic [3:0] slot, input logic [39:0] sec, input logic [27:0] cyc,
                         input logic late, input logic [27:0] tm);
    exp_t e;
    e.slot = slot;
    e.sec  = sec;
    e.cyc  = cyc;
    e.late = late;
    e.tm   = tm;
    sb.push_back(e);
  endtask

  task automatic waitTm(input logic [27:0] target, input int budget);
    int n = 0;
    while (tm_cyc != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (tm_cyc != target) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_tm timeout actual=%0h required=%0h", tm_cyc, target);
    end
  endtask

  // Monitor: every trig_o pulse must match the oldest expected fire, including the time it appeared.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (trig === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_trig actual slot=%0d cyc=%0h tm=%0h required none",
                 trig_slot, trig_cyc, tm_cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("trig_slot", 68'(trig_slot), 68'(e.slot));
        checkOutput("trig_sec",  68'(trig_sec),  68'(e.sec));
        checkOutput("trig_cyc",  68'(trig_cyc),  68'(e.cyc));
        checkOutput("trig_late", 68'(trig_late), 68'(e.late));
        checkOutput("trig_time", 68'(tm_cyc),    68'(e.tm));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    tm_valid   = 1'b0;
    tm_sec     = '0;
    tm_cyc     = '0;
    tm_run     = 1'b0;
    cfg_wr     = 1'b0;
    cfg_slot   = '0;
    cfg_sec    = '0;
    cfg_cyc    = '0;
    cfg_period = '0;
    cfg_count  = '0;
    cfg_disarm = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_trig",  68'(trig),      68'd0);
    checkOutput("rst_slot",  68'(trig_slot), 68'd0);
    checkOutput("rst_sec",   68'(trig_sec),  68'd0);
    checkOutput("rst_cyc",   68'(trig_cyc),  68'd0);
    checkOutput("rst_late",  68'(trig_late), 68'd0);
    checkOutput("rst_armed", 68'(armed),     68'd0);

    $display("[TB] out-of-range slot and wr/disarm collision");
    applyStimulus(1'b1, 4'd5, 40'hFF_FFFF_FFFF, 28'd0, 28'd0, 16'd0, 4'b0000);
    checkOutput("slot_oob", 68'(armed), 68'd0);
    applyStimulus(1'b1, 4'd3, 40'hFF_FFFF_FFFF, 28'd0, 28'd0, 16'd0, 4'b1000);
    checkOutput("wr_beats_disarm", 68'(armed), 68'b1000);
    applyStimulus(1'b0, 4'd0, 40'd0, 28'd0, 28'd0, 16'd0, 4'b1000);
    checkOutput("disarm", 68'(armed), 68'd0);

    $display("[TB] on-time fire slot 0");
    tm_sec   = S;
    tm_cyc   = 28'h0F00;
    tm_valid = 1'b1;
    tm_run   = 1'b1;
    pushExp(4'd0, S, 28'h1000, 1'b0, 28'h1002);
    applyStimulus(1'b1, 4'd0, S, 28'h1000, 28'd0, 16'd0, 4'b0000);
    checkOutput("armed_a", 68'(armed), 68'b0001);
    waitTm(28'h1010, 400);
    checkOutput("oneshot_a", 68'(armed), 68'd0);

    $display("[TB] same target slots 1 and 2");
    pushExp(4'd1, S, 28'h1100, 1'b0, 28'h1102);
    pushExp(4'd2, S, 28'h1100, 1'b0, 28'h1103);
    applyStimulus(1'b1, 4'd1, S, 28'h1100, 28'd0, 16'd0, 4'b0000);
    applyStimulus(1'b1, 4'd2, S, 28'h1100, 28'd0, 16'd0, 4'b0000);
    checkOutput("armed_b", 68'(armed), 68'b0110);
    waitTm(28'h1110, 400);
    checkOutput("oneshot_b", 68'(armed), 68'd0);

    $display("[TB] late target slot 3");
    x = tm_cyc;
    pushExp(4'd3, S, x - 28'd100, 1'b1, x + 28'd3);
    applyStimulus(1'b1, 4'd3, S, x - 28'd100, 28'd0, 16'd0, 4'b0000);
    repeat (8) @(negedge clk);
    checkOutput("oneshot_c", 68'(armed), 68'd0);

    $display("[TB] overwrite of a pending slot");
    x = tm_cyc;
    pushExp(4'd2, S, x + 28'd40, 1'b0, x + 28'd42);
    applyStimulus(1'b1, 4'd2, S, x - 28'd50, 28'd0, 16'd0, 4'b0000);
    @(negedge clk);
    applyStimulus(1'b1, 4'd2, S, x + 28'd40, 28'd0, 16'd0, 4'b0000);
    waitTm(x + 28'd50, 100);
    checkOutput("oneshot_ow", 68'(armed), 68'd0);

    $display("[TB] timebase invalid across target");
    x = tm_cyc;
    tm_valid = 1'b0;
    applyStimulus(1'b1, 4'd0, S, x + 28'd20, 28'd0, 16'd0, 4'b0000);
    waitTm(x + 28'd30, 100);
    checkOutput("armed_invalid", 68'(armed), 68'b0001);
    z = tm_cyc;
    pushExp(4'd0, S, x + 28'd20, 1'b1, z + 28'd2);
    tm_valid = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("oneshot_d", 68'(armed), 68'd0);

    $display("[TB] disarm in compare cycle");
    x = tm_cyc;
    applyStimulus(1'b1, 4'd0, S, x + 28'd10, 28'd0, 16'd0, 4'b0000);
    waitTm(x + 28'd10, 50);
    applyStimulus(1'b0, 4'd0, 40'd0, 28'd0, 28'd0, 16'd0, 4'b0001);
    repeat (5) @(negedge clk);
    checkOutput("disarm_cmp", 68'(armed), 68'd0);

    $display("[TB] reset between compare and output");
    x = tm_cyc;
    applyStimulus(1'b1, 4'd1, S, x + 28'd10, 28'd0, 16'd0, 4'b0000);
    waitTm(x + 28'd11, 50);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("rst_mid_armed", 68'(armed),    68'd0);
    checkOutput("rst_mid_sec",   68'(trig_sec), 68'd0);

`ifdef FMC_ADC_TIME_TRIG_PERIODIC_EN
    $display("[TB] periodic slot 0 across second boundary");
    tm_sec = S;
    tm_cyc = 28'd124999980;
    pushExp(4'd0, S,          28'd124999990, 1'b0, 28'd124999992);
    pushExp(4'd0, S + 40'd1,  28'd10,        1'b0, 28'd12);
    pushExp(4'd0, S + 40'd1,  28'd30,        1'b0, 28'd32);
    applyStimulus(1'b1, 4'd0, S, 28'd124999990, 28'd20, 16'd3, 4'b0000);
    checkOutput("armed_p", 68'(armed), 68'b0001);
    waitTm(28'd40, 200);
    checkOutput("periodic_done", 68'(armed), 68'd0);
`endif

    repeat (10) @(negedge clk);
    checkOutput("sb_empty", 68'(sb.size()), 68'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
